// File: rtl/mul4_fitness_scorer.sv
// Sequential fitness harness for a combinational mul4 candidate: drives operand
// vectors, computes the golden product by shift-add and scores bit matches.
module mul4_fitness_scorer #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED_A      = 32'hACE1_2468,
  parameter logic [31:0] SEED_B      = 32'h1357_9BDF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] a1,
  output logic [15:0] a0,
  output logic [15:0] b1,
  output logic [15:0] b0,
  input  logic [15:0] y3,
  input  logic [15:0] y2,
  input  logic [15:0] y1,
  input  logic [15:0] y0,
  output logic        busy,
  output logic        done,
  output logic [15:0] score,
  output logic [9:0]  passed
);

  typedef enum logic [2:0] {IDLE, DRIVE, MUL, SCORE, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] op_a, op_b, lfsr_a, lfsr_b;
  logic [31:0] step_a, step_b, nxt_a, nxt_b;
  logic [9:0]  idx, idx_nx;
  logic [63:0] ycap, acc, mcand, diff;
  logic [31:0] mplier;
  logic [4:0]  mcnt;
  logic [6:0]  ones, match;
  logic        last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  assign {a1, a0} = op_a;
  assign {b1, b0} = op_b;
  assign last     = (idx == 10'(NUM_VECTORS - 1));
  assign diff     = acc ^ ycap;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < 64; i++) ones = ones + 7'(diff[i]);
    match = 7'd64 - ones;
  end

  // Index 4 takes the seed as-is; the LFSR advances only after a vector it
  // supplied has been scored, so later vectors use the stepped value.
  always_comb begin
    idx_nx = idx + 10'd1;
    step_a = lfsr_step(lfsr_a);
    step_b = lfsr_step(lfsr_b);
    nxt_a  = (idx >= 10'd4) ? step_a : lfsr_a;
    nxt_b  = (idx >= 10'd4) ? step_b : lfsr_b;
    case (idx_nx)
      10'd1:   begin nxt_a = 32'hFFFF_FFFF; nxt_b = 32'hFFFF_FFFF; end
      10'd2:   begin nxt_a = 32'h0000_0001; nxt_b = 32'hFFFF_FFFF; end
      10'd3:   begin nxt_a = 32'h0001_0000; nxt_b = 32'h0001_0000; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = DRIVE;
      DRIVE:      state_nx = MUL;
      MUL:        if (mcnt == 5'd31) state_nx = SCORE;
      SCORE:      state_nx = last ? DONE : DRIVE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      lfsr_a <= SEED_A;
      lfsr_b <= SEED_B;
      idx    <= '0;
      ycap   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mcnt   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      score  <= '0;
      passed <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a   <= '0;
            op_b   <= '0;
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
            idx    <= '0;
            score  <= '0;
            passed <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        DRIVE: begin
          ycap   <= {y3, y2, y1, y0};
          acc    <= '0;
          mcand  <= {32'd0, op_a};
          mplier <= op_b;
          mcnt   <= '0;
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mcnt   <= mcnt + 5'd1;
        end
        SCORE: begin
          score <= score + 16'(match);
          if (diff == '0) passed <= passed + 10'd1;
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            idx  <= idx_nx;
            op_a <= nxt_a;
            op_b <= nxt_b;
            if (idx >= 10'd4) begin
              lfsr_a <= step_a;
              lfsr_b <= step_b;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Scoreboard bench: stimulus pushes expected operands/results from a
// behavioural model; a negedge monitor checks them against the DUT.
module tb_mul4_fitness_scorer;

  localparam int          NV = 6;
  localparam logic [31:0] SA = 32'hACE1_2468;
  localparam logic [31:0] SB = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic        busy, done;
  logic [15:0] score;
  logic [9:0]  passed;

  int          cand_mode = 0;
  logic [63:0] cand_mask = '0;
  int          total = 0;
  int          bad = 0;

  typedef struct { int sc; int ps; } res_t;
  logic [63:0] exp_ops[$];
  res_t        exp_res[$];

  mul4_fitness_scorer #(.NUM_VECTORS(NV), .SEED_A(SA), .SEED_B(SB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy), .done(done), .score(score), .passed(passed)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cand(input int mode, input logic [63:0] mask,
                                       input logic [31:0] va, input logic [31:0] vb);
    logic [63:0] p;
    p = 64'(va) * 64'(vb);
    case (mode)
      0:       return p;
      1:       return 64'd0;
      2:       return {va, vb};
      3:       return p ^ (mask & {va, vb});
      default: return p ^ (64'd1 << va[5:0]);
    endcase
  endfunction

  always_comb {y3, y2, y1, y0} = cand(cand_mode, cand_mask, {a1, a0}, {b1, b0});

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: vector list and score computed directly from the scoring rules.
  task automatic push_expect(input int mode, input logic [63:0] mask);
    logic [31:0] la, lb, va, vb;
    logic [63:0] p, y;
    res_t r;
    la = SA; lb = SB;
    r.sc = 0; r.ps = 0;
    for (int k = 0; k < NV; k++) begin
      case (k)
        0:       begin va = 32'h0;         vb = 32'h0;         end
        1:       begin va = 32'hFFFF_FFFF; vb = 32'hFFFF_FFFF; end
        2:       begin va = 32'h1;         vb = 32'hFFFF_FFFF; end
        3:       begin va = 32'h0001_0000; vb = 32'h0001_0000; end
        default: begin va = la; vb = lb; la = lstep(la); lb = lstep(lb); end
      endcase
      exp_ops.push_back({va, vb});
      p = 64'(va) * 64'(vb);
      y = cand(mode, mask, va, vb);
      r.sc += 64 - $countones(p ^ y);
      if (p == y) r.ps++;
    end
    exp_res.push_back(r);
  endtask

  // Monitor: cyc counts negedges after the start-accept edge.
  int   cyc = 0;
  bit   active = 0;
  res_t cur;
  logic [63:0] eo;
  always @(negedge clk) begin
    if (!rst_n) active = 0;
    else if (!active && busy) begin
      active = 1;
      cyc = 0;
      if (exp_res.size() == 0) begin
        chk("unexpected_start", 64'(exp_res.size()), 64'd1);
        cur.sc = -1; cur.ps = -1;
      end else cur = exp_res.pop_front();
    end
    if (active) begin
      if (cyc == 0) begin
        chk("clear_score", 64'(score), 64'd0);
        chk("clear_passed", 64'(passed), 64'd0);
        chk("clear_done", 64'(done), 64'd0);
      end
      if (cyc % 34 == 17) begin
        if (exp_ops.size() == 0) chk("ops_underflow", 64'(exp_ops.size()), 64'd1);
        else begin
          eo = exp_ops.pop_front();
          chk("operands", {a1, a0, b1, b0}, eo);
          if (cyc / 34 == 4) chk("v4_seed", {a1, a0, b1, b0}, {SA, SB});
        end
      end
      if (cyc == 34 * NV) begin
        chk("final_done", 64'(done), 64'd1);
        chk("final_busy", 64'(busy), 64'd0);
        chk("score", 64'(score), 64'(cur.sc));
        chk("passed", 64'(passed), 64'(cur.ps));
        active = 0;
      end else if (cyc % 34 == 5) begin
        chk("busy_mid", 64'(busy), 64'd1);
        chk("done_mid", 64'(done), 64'd0);
      end
      cyc++;
    end
  end

  task automatic run_start(input int mode, input logic [63:0] mask);
    cand_mode = mode;
    cand_mask = mask;
    push_expect(mode, mask);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 34 * NV + 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ops"}, {a1, a0, b1, b0}, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_score"}, 64'(score), 64'd0);
    chk({tag, "_passed"}, 64'(passed), 64'd0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ideal candidate, with a start pulse mid-run that must be ignored.
    run_start(0, '0);
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();

    // Restart straight from DONE with other candidates.
    run_start(1, '0);
    wait_done();
    run_start(2, '0);
    wait_done();
    for (int i = 0; i < 3; i++) begin
      run_start(3, {$urandom, $urandom});
      wait_done();
    end
    run_start(4, '0);
    wait_done();

    // Abort during v2's MUL phase, then rerun from scratch.
    run_start(1, '0);
    repeat (78) @(posedge clk);
    chk("partial_score", 64'(score), 64'd96);
    chk("partial_passed", 64'(passed), 64'd1);
    #2 rst_n = 1'b0;
    exp_ops.delete();
    exp_res.delete();
    #1 chk_zero_outputs("abort");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    run_start(1, '0);
    wait_done();

    chk("res_queue_empty", 64'(exp_res.size()), 64'd0);
    chk("ops_queue_empty", 64'(exp_ops.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
